// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/exec/mem/writeback sequencing for a
// small MIPS-like subset, with an instruction register and a retired counter.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_inc,
    output logic        need_jmp,
    output logic        b_or_j,
    output logic        br_ne,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [31:0] retired,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b110;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic [31:0] r_retired;
    logic        r_boot;
    logic        w_retire;
    logic [5:0]  w_op;
    logic        w_unused;

    assign w_op     = r_ir[31:26];
    assign w_unused = ^r_ir[25:0];
    assign state    = r_state;
    assign retired  = r_retired;

    // State, IR and retired counter; r_boot keeps the first post-reset cycle quiet
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ir      <= 32'd0;
            r_retired <= 32'd0;
            r_boot    <= 1'b1;
        end else begin
            r_state <= w_next;
            r_boot  <= 1'b0;
            if (ir_we) begin
                r_ir <= instr;
            end
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    // Next-state and strobe decode from state and IR; everything forced low in reset
    always_comb begin
        w_next      = S_FETCH;
        w_retire    = 1'b0;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_inc      = 1'b0;
        need_jmp    = 1'b0;
        b_or_j      = 1'b0;
        br_ne       = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_we      = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready && !r_boot) begin
                        ir_we  = 1'b1;
                        pc_inc = 1'b1;
                        w_next = S_DECODE;
                    end else begin
                        w_next = S_FETCH;
                    end
                end
                S_DECODE: w_next = S_EXEC;
                S_EXEC: begin
                    case (w_op)
                        OP_BEQ, OP_BNE: begin
                            need_jmp = 1'b1;
                            b_or_j   = 1'b1;
                            br_ne    = (w_op == OP_BNE);
                            alu_op   = ALU_SUB;
                            w_retire = 1'b1;
                            w_next   = S_FETCH;
                        end
                        OP_J: begin
                            need_jmp = 1'b1;
                            w_retire = 1'b1;
                            w_next   = S_FETCH;
                        end
                        OP_R: begin
                            alu_op = ALU_FUNCT;
                            w_next = S_WB;
                        end
                        OP_ADDI: begin
                            alu_src_imm = 1'b1;
                            w_next      = S_WB;
                        end
                        OP_ORI: begin
                            alu_op      = ALU_OR;
                            alu_src_imm = 1'b1;
                            w_next      = S_WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_src_imm = 1'b1;
                            w_next      = S_MEM;
                        end
                        default: begin
                            illegal = 1'b1;
                            w_next  = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (w_op == OP_SW);
                    if (!dmem_ready) begin
                        w_next = S_MEM;
                    end else if (w_op == OP_SW) begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = (w_op == OP_R);
                    mem_to_reg = (w_op == OP_LW);
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end
                default: w_next = S_FETCH;
            endcase
        end else begin
            w_next = S_FETCH;
        end
    end

endmodule
